// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and constants for the count_sequencer slice.
// Holds the FSM state encoding, the rate_sel encodings and the tick-period
// multipliers, plus a helper that turns rate_sel into a divider reload value.
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // rate_sel encodings
  localparam logic [1:0] RATE_CYCLE = 2'b00;
  localparam logic [1:0] RATE_1X    = 2'b01;
  localparam logic [1:0] RATE_2X    = 2'b10;
  localparam logic [1:0] RATE_4X    = 2'b11;

  // Tick period: one clock cycle, or a multiple of the base period
  localparam logic [31:0] PERIOD_CYCLE = 32'd1;
  localparam logic [31:0] MULT_1X      = 32'd1;
  localparam logic [31:0] MULT_2X      = 32'd2;
  localparam logic [31:0] MULT_4X      = 32'd4;

  // Divider reload value (period - 1) for a given rate selection.
  function automatic logic [31:0] reload_value(input logic [1:0]  rate,
                                               input logic [31:0] base);
    logic [31:0] period_s;
    case (rate)
      RATE_CYCLE: period_s = PERIOD_CYCLE;
      RATE_1X:    period_s = base * MULT_1X;
      RATE_2X:    period_s = base * MULT_2X;
      RATE_4X:    period_s = base * MULT_4X;
      default:    period_s = PERIOD_CYCLE;
    endcase
    return period_s - 32'd1;
  endfunction

endpackage

// File: rtl/count_sequencer_tick_divider.sv
// tick_divider: loadable DIV_W-bit down-counter with a zero flag.
// load has priority over enable; the counter parks at zero when enabled.
module tick_divider #(
  parameter int unsigned DIV_W = 28
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] load_value,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_r;

  // Down-counter register: load, decrement while enabled, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_value;
    end else if (enable && (cnt_r != {DIV_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {DIV_W{1'b0}});

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/stop controller for the 4-bit display counter.
// A tick divider paces a bounded up/down counter; limit and direction are
// latched on start from IDLE/DONE. All outputs are registered.
// Optional build macro COUNT_SEQ_AUTORELOAD_EN: the counter reloads to its
// start value on the tick after reaching terminal instead of halting in DONE.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned DIV_W       = 28
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] rate_sel,
  input  logic       up_down,
  input  logic [3:0] limit,
  output logic [3:0] count,
  output logic       tick,
  output logic       busy,
  output logic       done
);

`ifdef COUNT_SEQ_AUTORELOAD_EN
  // A zero limit keeps running with count pinned at zero.
  localparam state_t ZERO_LIMIT_STATE = ST_RUN;
`else
  // A zero limit is already at terminal, so finish immediately.
  localparam state_t ZERO_LIMIT_STATE = ST_DONE;
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       count_r;
  logic [3:0]       count_nxt_s;
  logic             tick_r;
  logic             tick_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic [3:0]       limit_r;
  logic [3:0]       limit_nxt_s;
  logic             dir_r;
  logic             dir_nxt_s;
  logic             div_load_s;
  logic             div_en_s;
  logic             div_zero_s;
  logic [DIV_W-1:0] reload_s;
  logic [3:0]       term_s;
  logic [3:0]       origin_s;
  logic [3:0]       step_s;

  // Reload value follows the live rate_sel, so a change only lands at a reload.
  assign reload_s = DIV_W'(reload_value(rate_sel, BASE_PERIOD));

  // Terminal and origin of the latched run, and the next stepped count.
  assign term_s   = dir_r ? limit_r : 4'd0;
  assign origin_s = dir_r ? 4'd0 : limit_r;
  assign step_s   = dir_r ? (count_r + 4'd1) : (count_r - 4'd1);

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_tick_divider (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (div_load_s),
    .enable     (div_en_s),
    .load_value (reload_s),
    .zero       (div_zero_s)
  );

  // Next-state, next-count and divider control; stop always beats start.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    tick_nxt_s  = 1'b0;
    limit_nxt_s = limit_r;
    dir_nxt_s   = dir_r;
    div_load_s  = 1'b0;
    div_en_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = 4'd0;
        end else if (start) begin
          limit_nxt_s = limit;
          dir_nxt_s   = up_down;
          count_nxt_s = up_down ? 4'd0 : limit;
          div_load_s  = 1'b1;
          if (limit == 4'd0) begin
            state_nxt_s = ZERO_LIMIT_STATE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt_s = ST_PAUSE;
        end else if (div_zero_s) begin
          div_load_s = 1'b1;
          tick_nxt_s = 1'b1;
`ifdef COUNT_SEQ_AUTORELOAD_EN
          if (count_r == term_s) begin
            count_nxt_s = origin_s;
          end else begin
            count_nxt_s = step_s;
          end
`else
          count_nxt_s = step_s;
          if (step_s == term_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
`endif
        end else begin
          div_en_s = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = 4'd0;
        end else if (start) begin
          state_nxt_s = ST_RUN;
          div_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = 4'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counter, latched run parameters and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 4'd0;
      tick_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      limit_r <= 4'd0;
      dir_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tick_r  <= tick_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      limit_r <= limit_nxt_s;
      dir_r   <= dir_nxt_s;
    end
  end

  assign count = count_r;
  assign tick  = tick_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed self-checking bench for count_sequencer,
// built with BASE_PERIOD=4 so rate 01 = 4 cycles, 10 = 8, 11 = 16.
module tb_count_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [1:0] rate_sel;
  logic       up_down;
  logic [3:0] limit;
  logic [3:0] count;
  logic       tick;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  count_sequencer #(
    .BASE_PERIOD (4),
    .DIV_W       (8)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .rate_sel (rate_sel),
    .up_down  (up_down),
    .limit    (limit),
    .count    (count),
    .tick     (tick),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n cycles; inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    rate_sel = 2'b00;
    up_down  = 1'b1;
    limit    = 4'd0;

    // Reset values
    step(2);
    check("rst_count", count, 4'd0);
    check("rst_tick", 4'(tick), 4'd0);
    check("rst_busy", 4'(busy), 4'd0);
    check("rst_done", 4'(done), 4'd0);
    reset_n = 1'b1;
    step(1);
    check("idle_busy", 4'(busy), 4'd0);

    // Up run at rate 00: 0,1,2,3 on consecutive cycles, then DONE
    limit = 4'd3; up_down = 1'b1; rate_sel = 2'b00;
    pulse_start();
    check("up_first_count", count, 4'd0);
    check("up_first_busy", 4'(busy), 4'd1);
    check("up_first_tick", 4'(tick), 4'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check($sformatf("up_count_%0d", i), count, 4'(i));
      check($sformatf("up_tick_%0d", i), 4'(tick), 4'd1);
      check($sformatf("up_done_%0d", i), 4'(done), 4'((i == 3) ? 1 : 0));
      check($sformatf("up_busy_%0d", i), 4'(busy), 4'((i == 3) ? 0 : 1));
    end
    step(1);
    check("up_hold_count", count, 4'd3);
    check("up_hold_tick", 4'(tick), 4'd0);
    check("up_hold_done", 4'(done), 4'd1);

    // Slow rate 01 with a switch to 10 after the first tick
    limit = 4'd3; up_down = 1'b1; rate_sel = 2'b01;
    pulse_start();
    check("slow_start_count", count, 4'd0);
    check("slow_start_done", 4'(done), 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("slow_p1_notick", 4'(tick), 4'd0);
    end
    step(1);
    check("slow_t1_tick", 4'(tick), 4'd1);
    check("slow_t1_count", count, 4'd1);
    rate_sel = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("slow_p2_notick", 4'(tick), 4'd0);
    end
    step(1);
    check("slow_t2_tick", 4'(tick), 4'd1);
    check("slow_t2_count", count, 4'd2);
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("slow_p3_notick", 4'(tick), 4'd0);
      check("slow_p3_count", count, 4'd2);
    end
    step(1);
    check("slow_t3_tick", 4'(tick), 4'd1);
    check("slow_t3_count", count, 4'd3);
    check("slow_t3_done", 4'(done), 4'd1);
    check("slow_t3_busy", 4'(busy), 4'd0);

    // Pause/resume counting down from 5 at rate 01
    limit = 4'd5; up_down = 1'b0; rate_sel = 2'b01;
    pulse_start();
    check("dn_start_count", count, 4'd5);
    step(3);
    check("dn_p1_notick", 4'(tick), 4'd0);
    step(1);
    check("dn_t1_count", count, 4'd4);
    pulse_stop();
    check("pause_busy", 4'(busy), 4'd0);
    check("pause_count", count, 4'd4);
    limit = 4'd9; up_down = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("pause_hold_count", count, 4'd4);
      check("pause_hold_tick", 4'(tick), 4'd0);
    end
    pulse_start();
    check("resume_busy", 4'(busy), 4'd1);
    check("resume_count", count, 4'd4);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("resume_notick", 4'(tick), 4'd0);
    end
    step(1);
    check("resume_tick", 4'(tick), 4'd1);
    check("resume_count_dn", count, 4'd3);
    pulse_stop();
    check("stop1_busy", 4'(busy), 4'd0);
    check("stop1_count", count, 4'd3);
    pulse_stop();
    check("stop2_count", count, 4'd0);
    check("stop2_done", 4'(done), 4'd0);

    // start+stop together: IDLE stays IDLE, RUN goes to PAUSE
    limit = 4'd5; up_down = 1'b1; rate_sel = 2'b00;
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("ss_idle_busy", 4'(busy), 4'd0);
    step(2);
    check("ss_idle_busy_later", 4'(busy), 4'd0);
    check("ss_idle_count", count, 4'd0);
    limit = 4'd9;
    pulse_start();
    step(1);
    check("ss_run_count", count, 4'd1);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("ss_run_busy", 4'(busy), 4'd0);
    check("ss_run_tick", 4'(tick), 4'd0);
    step(3);
    check("ss_pause_count", count, 4'd1);
    check("ss_pause_busy", 4'(busy), 4'd0);
    pulse_stop();
    check("ss_clear_count", count, 4'd0);

    // Zero limit
    limit = 4'd0; up_down = 1'b1; rate_sel = 2'b00;
    pulse_start();
    check("zero_count", count, 4'd0);
    check("zero_tick", 4'(tick), 4'd0);
`ifdef COUNT_SEQ_AUTORELOAD_EN
    check("zero_busy", 4'(busy), 4'd1);
    check("zero_done", 4'(done), 4'd0);
    step(1);
    check("zero_run_tick", 4'(tick), 4'd1);
    check("zero_run_count", count, 4'd0);
`else
    check("zero_done", 4'(done), 4'd1);
    check("zero_busy", 4'(busy), 4'd0);
    step(2);
    check("zero_hold_tick", 4'(tick), 4'd0);
    check("zero_hold_done", 4'(done), 4'd1);
`endif
    pulse_stop();
    pulse_stop();
    check("zero_clear_busy", 4'(busy), 4'd0);

    // Terminal behaviour with limit 2 up at rate 00
    limit = 4'd2; up_down = 1'b1; rate_sel = 2'b00;
    pulse_start();
    check("term_start_count", count, 4'd0);
`ifdef COUNT_SEQ_AUTORELOAD_EN
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check($sformatf("reload_count_%0d", i), count, 4'(i % 3));
      check("reload_tick", 4'(tick), 4'd1);
      check("reload_done", 4'(done), 4'd0);
    end
`else
    step(1);
    check("term_count_1", count, 4'd1);
    step(1);
    check("term_count_2", count, 4'd2);
    check("term_done", 4'(done), 4'd1);
    step(1);
    check("term_hold_count", count, 4'd2);
    check("term_hold_tick", 4'(tick), 4'd0);
`endif
    pulse_stop();
    pulse_stop();

    // Asynchronous reset mid-RUN at count 7
    limit = 4'd15; up_down = 1'b1; rate_sel = 2'b00;
    pulse_start();
    step(7);
    check("pre_rst_count", count, 4'd7);
    check("pre_rst_busy", 4'(busy), 4'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_count", count, 4'd0);
    check("async_rst_busy", 4'(busy), 4'd0);
    check("async_rst_tick", 4'(tick), 4'd0);
    step(1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("post_rst_busy", 4'(busy), 4'd0);
      check("post_rst_tick", 4'(tick), 4'd0);
      check("post_rst_count", count, 4'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
